// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: PC strobe in, instruction-memory req/ack, decoder valid/ready out.
interface instr_fetch_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              fetch_start;
    logic [ADDR_W-1:0] pc_addr;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic              instr_valid;
    logic              instr_ready;
    logic [DATA_W-1:0] instr_data;
    logic [ADDR_W-1:0] instr_addr;
    logic              busy;
    logic              fetch_err;

    modport master (
        input  fetch_start, pc_addr, mem_ack, mem_rdata, instr_ready,
        output mem_req, mem_addr, instr_valid, instr_data, instr_addr, busy, fetch_err
    );

    modport slave (
        output fetch_start, pc_addr, mem_ack, mem_rdata, instr_ready,
        input  mem_req, mem_addr, instr_valid, instr_data, instr_addr, busy, fetch_err
    );
endinterface

// File: rtl/instr_fetch.sv
// Fetch stage: one memory read per PC strobe, word held for decoder; strobe-to-valid >= 2 cycles.
// Decoder stall holds the word; a new strobe redirects (in flight) or drops the held word.
module instr_fetch #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic           clk,
    input  logic           rst,
    instr_fetch_if.master  bus
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              pend;
    logic [ADDR_W-1:0] pend_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            cnt             <= '0;
            pend            <= 1'b0;
            pend_addr       <= '0;
            bus.mem_req     <= 1'b0;
            bus.mem_addr    <= '0;
            bus.instr_valid <= 1'b0;
            bus.instr_data  <= '0;
            bus.instr_addr  <= '0;
            bus.busy        <= 1'b0;
            bus.fetch_err   <= 1'b0;
        end else begin
            bus.fetch_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.fetch_start) begin
                        state        <= REQ;
                        bus.mem_req  <= 1'b1;
                        bus.mem_addr <= bus.pc_addr;
                        bus.busy     <= 1'b1;
                        cnt          <= '0;
                    end
                end

                REQ: begin
                    if (!bus.mem_req) begin
                        // Turnaround cycle after a redirect; address is still free to move.
                        bus.mem_req <= 1'b1;
                        if (bus.fetch_start)
                            bus.mem_addr <= bus.pc_addr;
                    end else if (bus.mem_ack) begin
                        bus.mem_req <= 1'b0;
                        cnt         <= '0;
                        if (pend || bus.fetch_start) begin
                            // Returned word belongs to a stale address: discard and reissue.
                            bus.mem_addr <= bus.fetch_start ? bus.pc_addr : pend_addr;
                            pend         <= 1'b0;
                        end else begin
                            bus.instr_data  <= bus.mem_rdata;
                            bus.instr_addr  <= bus.mem_addr;
                            bus.instr_valid <= 1'b1;
                            state           <= HOLD;
                        end
                    end else if (cnt == CNT_LAST) begin
                        bus.mem_req   <= 1'b0;
                        bus.fetch_err <= 1'b1;
                        bus.busy      <= 1'b0;
                        pend          <= 1'b0;
                        cnt           <= '0;
                        state         <= IDLE;
                    end else begin
                        // The abort compare above stops cnt before it can wrap.
                        cnt <= cnt + 1'b1;
                        if (bus.fetch_start) begin
                            pend      <= 1'b1;
                            pend_addr <= bus.pc_addr;
                        end
                    end
                end

                HOLD: begin
                    if (bus.fetch_start) begin
                        bus.instr_valid <= 1'b0;
                        bus.mem_req     <= 1'b1;
                        bus.mem_addr    <= bus.pc_addr;
                        cnt             <= '0;
                        state           <= REQ;
                    end else if (bus.instr_ready) begin
                        bus.instr_valid <= 1'b0;
                        bus.busy        <= 1'b0;
                        state           <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
